dac_update_sched: RTL and testbench
===================================

Name: dac_update_sched

Overview:
- Schedules 16-bit DAC code updates onto the single-CS SPI master that drives the DAC, replacing free-running count-based triggering.
- Two requesters share the DAC: the DPLL loop (PID output path) and a manual/switch source.
- Arbitrates between them, clamps each code, splits it into MSB/LSB bytes and sequences the two-byte SPI transaction with a ready/valid handshake.
- Enforces a minimum inter-update gap and a ready timeout.

Parameters:
- GAP_CYCLES, 64: minimum idle clocks between the end of one update and the next DV.
- TIMEOUT_CYCLES, 4096: max clocks waiting for i_TX_Ready before abort.
- CODE_MIN, 16'h0000: lower clamp for DAC code.
- CODE_MAX, 16'hFFFF: upper clamp for DAC code.

Ports:
- i_Clk  in  1  system clock (50 MHz domain)
- i_Rst_L  in  1  asynchronous active-low reset
- i_Loop_Code  in  16  DAC code from DPLL loop
- i_Loop_Valid  in  1  single-cycle loop request strobe
- i_Man_Code  in  16  manual DAC code
- i_Man_Valid  in  1  single-cycle manual request strobe
- i_Man_Override  in  1  level; 1 = loop requests ignored
- o_TX_Byte  out  8  byte to SPI master
- o_TX_DV  out  1  byte valid to SPI master, one-cycle pulse
- o_TX_Count  out  2  bytes per CS frame, constant 2
- i_TX_Ready  in  1  SPI master ready
- o_Busy  out  1  transaction or gap in progress
- o_Update_Done  out  1  one-cycle pulse when an update completes
- o_Last_Code  out  16  last code fully sent
- o_Last_Src  out  1  source of last code (0 = loop, 1 = manual)
- o_Drop_Count  out  8  saturating count of overwritten/ignored requests
- o_Timeout_Err  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock, i_Clk. i_Rst_L is asynchronous and active-low.
- Reset values: all outputs 0, except o_TX_Count = 2. FSM to IDLE. Pending flags, round-robin pointer (rr = loop) and gap counter cleared.
- Request capture:
  - A strobe registers clamp(code) into that source's pending slot and sets its pending flag.
  - If the slot is already pending, the new code overwrites it (latest wins) and o_Drop_Count increments (saturates at 255).
  - i_Loop_Valid while i_Man_Override = 1 is ignored and counted as a drop.
  - Asserting i_Man_Override clears any loop pending flag, with no extra drop count.
- Clamp: code < CODE_MIN becomes CODE_MIN; code > CODE_MAX becomes CODE_MAX. Unsigned compare.
- Arbitration in IDLE (needs at least one pending and i_TX_Ready = 1):
  - Only one pending: grant that source.
  - Both pending: grant the source selected by rr, then toggle rr.
  - Grant copies the slot into a shadow register and clears its pending flag.
  - A strobe from the granted source in the grant cycle re-sets pending with the new code.
- FSM:
  - IDLE: on grant, o_TX_DV = 1 and o_TX_Byte = shadow[15:8]; go to WAIT1.
  - WAIT1: wait for i_TX_Ready to rise (low then high), go to SEND2.
  - SEND2: o_TX_DV = 1, o_TX_Byte = shadow[7:0]; go to WAIT2.
  - WAIT2: wait for i_TX_Ready high again, then:
    - pulse o_Update_Done;
    - load o_Last_Code and o_Last_Src;
    - go to GAP.
  - GAP: count GAP_CYCLES, then return to IDLE. GAP_CYCLES = 0 returns to IDLE next cycle.
- Latency: strobe at edge N gives pending at N+1. DV is asserted in cycle N+1 if IDLE and ready.
- o_TX_DV is never high two consecutive cycles. o_TX_Byte is held stable outside DV cycles.
- Timeout:
  - WAIT1/WAIT2 count cycles since entry; reaching TIMEOUT_CYCLES sets o_Timeout_Err (sticky until reset) and goes to GAP.
  - No o_Update_Done and o_Last_Code is unchanged. The aborted code is discarded.
- o_Busy = 1 in every state except IDLE.
- Reset mid-transaction: immediate return to reset state. No DV after reset deassertion until a new request arrives.

Decomposition:
- Shared package (dpll_pkg):
  - FSM state enum (IDLE, WAIT1, SEND2, WAIT2, GAP);
  - source encoding constants SRC_LOOP = 0 and SRC_MAN = 1;
  - DAC_W = 16.
- One natural sub-module, dac_req_slot: clamp + pending register + overwrite/drop flag; instantiated once per source.

Test Plan:
- Single manual request 16'hA55A, GAP_CYCLES = 4 -> DV pulses with bytes 8'hA5 then 8'h5A; o_Update_Done once; o_Last_Code = 16'hA55A, o_Last_Src = 1.
- Loop and manual strobed in the same cycle, override = 0 -> loop sent first (rr reset), manual sent after the gap; no drops.
- Three loop strobes (100, 200, 300) while busy -> only 300 sent next; o_Drop_Count = 1.
- CODE_MAX = 16'h8000, request 16'hFFFF -> bytes 8'h80, 8'h00.
- Override = 1 with a loop strobe -> no transaction; o_Drop_Count increments; a following manual request is served.
- i_TX_Ready held low after the first DV, TIMEOUT_CYCLES = 16 -> o_Timeout_Err set at cycle 16; no o_Update_Done; FSM back in IDLE after the gap.

Source files
------------

// File: rtl/dpll_pkg.sv
// Shared types and constants for the DAC update scheduler.
package dpll_pkg;

  localparam int DAC_W = 16;

  localparam logic SRC_LOOP = 1'b0;
  localparam logic SRC_MAN  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT1,
    SEND2,
    WAIT2,
    GAP
  } sched_state_t;

  function automatic logic [DAC_W-1:0] clamp_code(
    input logic [DAC_W-1:0] code,
    input logic [DAC_W-1:0] lo,
    input logic [DAC_W-1:0] hi
  );
    if (code < lo) return lo;
    else if (code > hi) return hi;
    else return code;
  endfunction

endpackage

// File: rtl/dac_update_sched_if.sv
// Request, SPI-master handshake and status signals of the DAC update scheduler.
interface dac_update_sched_if;
  import dpll_pkg::*;

  logic [DAC_W-1:0] i_Loop_Code;
  logic             i_Loop_Valid;
  logic [DAC_W-1:0] i_Man_Code;
  logic             i_Man_Valid;
  logic             i_Man_Override;
  logic [7:0]       o_TX_Byte;
  logic             o_TX_DV;
  logic [1:0]       o_TX_Count;
  logic             i_TX_Ready;
  logic             o_Busy;
  logic             o_Update_Done;
  logic [DAC_W-1:0] o_Last_Code;
  logic             o_Last_Src;
  logic [7:0]       o_Drop_Count;
  logic             o_Timeout_Err;

  modport slave (
    input  i_Loop_Code, i_Loop_Valid, i_Man_Code, i_Man_Valid, i_Man_Override, i_TX_Ready,
    output o_TX_Byte, o_TX_DV, o_TX_Count, o_Busy, o_Update_Done, o_Last_Code, o_Last_Src,
           o_Drop_Count, o_Timeout_Err
  );

  modport master (
    output i_Loop_Code, i_Loop_Valid, i_Man_Code, i_Man_Valid, i_Man_Override, i_TX_Ready,
    input  o_TX_Byte, o_TX_DV, o_TX_Count, o_Busy, o_Update_Done, o_Last_Code, o_Last_Src,
           o_Drop_Count, o_Timeout_Err
  );

endinterface

// File: rtl/dac_req_slot.sv
// One requester's pending slot: clamps the strobed code and holds it until granted.
// o_drop flags a strobe that overwrote an unserved code or was blocked.
module dac_req_slot import dpll_pkg::*; #(
  parameter logic [DAC_W-1:0] CODE_MIN = 16'h0000,
  parameter logic [DAC_W-1:0] CODE_MAX = 16'hFFFF
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic [DAC_W-1:0] i_code,
  input  logic             i_valid,
  input  logic             i_block,
  input  logic             i_grant,
  output logic             o_pending,
  output logic [DAC_W-1:0] o_code,
  output logic             o_drop
);

  logic             pending_q, pending_d;
  logic [DAC_W-1:0] code_q, code_d;

  always_comb begin
    pending_d = pending_q;
    code_d    = code_q;
    o_drop    = 1'b0;
    if (i_valid && i_block) begin
      o_drop = 1'b1;
    end else if (i_valid) begin
      // a strobe in the grant cycle re-arms the slot rather than overwriting
      o_drop    = pending_q && !i_grant;
      pending_d = 1'b1;
      code_d    = clamp_code(i_code, CODE_MIN, CODE_MAX);
    end else if (i_grant) begin
      pending_d = 1'b0;
    end
    if (i_block) pending_d = 1'b0;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      pending_q <= 1'b0;
      code_q    <= '0;
    end else begin
      pending_q <= pending_d;
      code_q    <= code_d;
    end
  end

  assign o_pending = pending_q;
  assign o_code    = code_q;

endmodule

// File: rtl/dac_update_sched.sv
// Arbitrates loop/manual DAC codes and sequences the two-byte SPI write with gap and timeout.
//   state | meaning
//   IDLE  | no transfer; grant a pending slot when the SPI master is ready, send MSB
//   WAIT1 | MSB handed off; wait for ready low-then-high (or timeout)
//   SEND2 | one cycle presenting the LSB
//   WAIT2 | LSB handed off; wait for ready low-then-high (or timeout)
//   GAP   | enforced idle time before the next grant
module dac_update_sched import dpll_pkg::*; #(
  parameter int unsigned      GAP_CYCLES     = 64,
  parameter int unsigned      TIMEOUT_CYCLES = 4096,
  parameter logic [DAC_W-1:0] CODE_MIN       = 16'h0000,
  parameter logic [DAC_W-1:0] CODE_MAX       = 16'hFFFF
) (
  input logic              i_Clk,
  input logic              i_Rst_L,
  dac_update_sched_if.slave bus
);

  localparam int unsigned TMR_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int          TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  sched_state_t     state_q, state_d;
  logic [DAC_W-1:0] shadow_q, shadow_d;
  logic             src_q, src_d;
  logic             rr_q, rr_d;
  logic [7:0]       byte_q, byte_d;
  logic             dv_q, dv_d;
  logic             done_q, done_d;
  logic [DAC_W-1:0] last_code_q, last_code_d;
  logic             last_src_q, last_src_d;
  logic [7:0]       drop_q, drop_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             seen_low_q, seen_low_d;

  logic             loop_pend, man_pend, loop_drop, man_drop;
  logic [DAC_W-1:0] loop_code, man_code, grant_code;
  logic             loop_req, man_req, grant_any, grant_src;
  logic [8:0]       drop_sum;

  assign loop_req   = loop_pend && !bus.i_Man_Override;
  assign man_req    = man_pend;
  assign grant_any  = (state_q == IDLE) && bus.i_TX_Ready && (loop_req || man_req);
  assign grant_src  = (loop_req && man_req) ? rr_q : (man_req ? SRC_MAN : SRC_LOOP);
  assign grant_code = (grant_src == SRC_MAN) ? man_code : loop_code;

  dac_req_slot #(.CODE_MIN(CODE_MIN), .CODE_MAX(CODE_MAX)) u_loop_slot (
    .i_Clk     (i_Clk),
    .i_Rst_L   (i_Rst_L),
    .i_code    (bus.i_Loop_Code),
    .i_valid   (bus.i_Loop_Valid),
    .i_block   (bus.i_Man_Override),
    .i_grant   (grant_any && (grant_src == SRC_LOOP)),
    .o_pending (loop_pend),
    .o_code    (loop_code),
    .o_drop    (loop_drop)
  );

  dac_req_slot #(.CODE_MIN(CODE_MIN), .CODE_MAX(CODE_MAX)) u_man_slot (
    .i_Clk     (i_Clk),
    .i_Rst_L   (i_Rst_L),
    .i_code    (bus.i_Man_Code),
    .i_valid   (bus.i_Man_Valid),
    .i_block   (1'b0),
    .i_grant   (grant_any && (grant_src == SRC_MAN)),
    .o_pending (man_pend),
    .o_code    (man_code),
    .o_drop    (man_drop)
  );

  assign drop_sum = {1'b0, drop_q} + {8'd0, loop_drop} + {8'd0, man_drop};
  assign drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    src_d       = src_q;
    rr_d        = rr_q;
    byte_d      = byte_q;
    dv_d        = 1'b0;
    done_d      = 1'b0;
    last_code_d = last_code_q;
    last_src_d  = last_src_q;
    err_d       = err_q;
    tmr_d       = tmr_q;
    seen_low_d  = seen_low_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d    = WAIT1;
          shadow_d   = grant_code;
          src_d      = grant_src;
          dv_d       = 1'b1;
          byte_d     = grant_code[15:8];
          tmr_d      = TO_LOAD;
          seen_low_d = 1'b0;
          if (loop_req && man_req) rr_d = !rr_q;
        end
      end
      WAIT1, WAIT2: begin
        // ready may still be high from before the master saw DV, so require a low first
        if (bus.i_TX_Ready && seen_low_q) begin
          if (state_q == WAIT1) begin
            state_d = SEND2;
            dv_d    = 1'b1;
            byte_d  = shadow_q[7:0];
          end else begin
            state_d     = GAP;
            done_d      = 1'b1;
            last_code_d = shadow_q;
            last_src_d  = src_q;
            tmr_d       = GAP_LOAD;
          end
        end else if (tmr_q == '0) begin
          state_d = GAP;
          err_d   = 1'b1;
          tmr_d   = GAP_LOAD;
        end else begin
          tmr_d = tmr_q - 1'b1;
          if (!bus.i_TX_Ready) seen_low_d = 1'b1;
        end
      end
      SEND2: begin
        state_d    = WAIT2;
        tmr_d      = TO_LOAD;
        seen_low_d = 1'b0;
      end
      GAP: begin
        if (tmr_q == '0) state_d = IDLE;
        else tmr_d = tmr_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      src_q       <= SRC_LOOP;
      rr_q        <= SRC_LOOP;
      byte_q      <= '0;
      dv_q        <= 1'b0;
      done_q      <= 1'b0;
      last_code_q <= '0;
      last_src_q  <= 1'b0;
      drop_q      <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      tmr_q       <= '0;
      seen_low_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      src_q       <= src_d;
      rr_q        <= rr_d;
      byte_q      <= byte_d;
      dv_q        <= dv_d;
      done_q      <= done_d;
      last_code_q <= last_code_d;
      last_src_q  <= last_src_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      tmr_q       <= tmr_d;
      seen_low_q  <= seen_low_d;
    end
  end

  assign bus.o_TX_Byte     = byte_q;
  assign bus.o_TX_DV       = dv_q;
  assign bus.o_TX_Count    = 2'd2;
  assign bus.o_Busy        = busy_q;
  assign bus.o_Update_Done = done_q;
  assign bus.o_Last_Code   = last_code_q;
  assign bus.o_Last_Src    = last_src_q;
  assign bus.o_Drop_Count  = drop_q;
  assign bus.o_Timeout_Err = err_q;

endmodule

// File: tb/tb_dac_update_sched.sv
// Bench for dac_update_sched: two instances in lockstep (full range and clamped range)
// behind a simple SPI-master ready model.
module tb_dac_update_sched;
  import dpll_pkg::*;

  localparam int GAP = 4;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic stall;
  always #5 clk = ~clk;

  dac_update_sched_if bus_a ();
  dac_update_sched_if bus_b ();

  assign bus_b.i_Loop_Code    = bus_a.i_Loop_Code;
  assign bus_b.i_Loop_Valid   = bus_a.i_Loop_Valid;
  assign bus_b.i_Man_Code     = bus_a.i_Man_Code;
  assign bus_b.i_Man_Valid    = bus_a.i_Man_Valid;
  assign bus_b.i_Man_Override = bus_a.i_Man_Override;
  assign bus_b.i_TX_Ready     = bus_a.i_TX_Ready;

  dac_update_sched #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut_a (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (bus_a)
  );

  dac_update_sched #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO),
                     .CODE_MIN(16'h0010), .CODE_MAX(16'h8000)) dut_b (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (bus_b)
  );

  typedef struct {
    logic        src;
    logic [15:0] code;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs[7];

  int total = 0;
  int bad   = 0;
  int n_dv, n_done, b2b, unstable, desync;
  logic [7:0] by_a[8];
  logic [7:0] by_b[8];
  int dv_t[8];
  int done_t[4];

  // SPI master: ready drops after each DV for three cycles; stall holds it low
  initial begin
    int   cnt;
    logic sampled;
    cnt = 0;
    bus_a.i_TX_Ready = 1'b1;
    forever begin
      @(negedge clk);
      sampled = bus_a.o_TX_DV;
      @(posedge clk);
      #1;
      if (sampled) begin
        bus_a.i_TX_Ready = 1'b0;
        cnt = 3;
      end else if (!stall) begin
        if (cnt > 1) cnt--;
        else bus_a.i_TX_Ready = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic req(input logic src, input logic [15:0] code);
    @(posedge clk);
    #1;
    if (src) begin
      bus_a.i_Man_Code  = code;
      bus_a.i_Man_Valid = 1'b1;
    end else begin
      bus_a.i_Loop_Code  = code;
      bus_a.i_Loop_Valid = 1'b1;
    end
    @(posedge clk);
    #1;
    bus_a.i_Man_Valid  = 1'b0;
    bus_a.i_Loop_Valid = 1'b0;
  endtask

  task automatic collect(input int cycles);
    logic       prev_dv;
    logic [7:0] prev_byte;
    n_dv = 0; n_done = 0; b2b = 0; unstable = 0; desync = 0;
    prev_dv   = bus_a.o_TX_DV;
    prev_byte = bus_a.o_TX_Byte;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus_a.o_TX_DV !== bus_b.o_TX_DV || bus_a.o_Update_Done !== bus_b.o_Update_Done)
        desync++;
      if (bus_a.o_TX_DV) begin
        if (prev_dv) b2b++;
        if (n_dv < 8) begin
          by_a[n_dv] = bus_a.o_TX_Byte;
          by_b[n_dv] = bus_b.o_TX_Byte;
          dv_t[n_dv] = i;
        end
        n_dv++;
      end else if (bus_a.o_TX_Byte !== prev_byte) begin
        unstable++;
      end
      if (bus_a.o_Update_Done) begin
        if (n_done < 4) done_t[n_done] = i;
        n_done++;
      end
      prev_dv   = bus_a.o_TX_DV;
      prev_byte = bus_a.o_TX_Byte;
    end
  endtask

  task automatic chk_bytes(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
    chk({nm, " n_dv"}, 32'(n_dv), 32'd4);
    chk({nm, " b0"}, 32'(by_a[0]), 32'(e0));
    chk({nm, " b1"}, 32'(by_a[1]), 32'(e1));
    chk({nm, " b2"}, 32'(by_a[2]), 32'(e2));
    chk({nm, " b3"}, 32'(by_a[3]), 32'(e3));
    chk({nm, " n_done"}, 32'(n_done), 32'd2);
    chk({nm, " b2b_dv"}, 32'(b2b), 32'd0);
  endtask

  initial begin
    int t_dv, t_err, t_idle, nd, ndv;

    vecs[0] = '{1'b1, 16'hA55A, 16'hA55A, 16'h8000};
    vecs[1] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h8000};
    vecs[2] = '{1'b0, 16'h1234, 16'h1234, 16'h1234};
    vecs[3] = '{1'b0, 16'h0003, 16'h0003, 16'h0010};
    vecs[4] = '{1'b1, 16'h8000, 16'h8000, 16'h8000};
    vecs[5] = '{1'b0, 16'h8001, 16'h8001, 16'h8000};
    vecs[6] = '{1'b1, 16'h0010, 16'h0010, 16'h0010};

    stall = 1'b0;
    rst_n = 1'b0;
    bus_a.i_Loop_Code = '0; bus_a.i_Loop_Valid = 1'b0;
    bus_a.i_Man_Code  = '0; bus_a.i_Man_Valid  = 1'b0;
    bus_a.i_Man_Override = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst dv", 32'(bus_a.o_TX_DV), 32'd0);
    chk("rst byte", 32'(bus_a.o_TX_Byte), 32'd0);
    chk("rst count", 32'(bus_a.o_TX_Count), 32'd2);
    chk("rst busy", 32'(bus_a.o_Busy), 32'd0);
    chk("rst done", 32'(bus_a.o_Update_Done), 32'd0);
    chk("rst last", 32'(bus_a.o_Last_Code), 32'd0);
    chk("rst drop", 32'(bus_a.o_Drop_Count), 32'd0);
    chk("rst err", 32'(bus_a.o_Timeout_Err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single requests, full range on A and clamped range on B
    for (int k = 0; k < 7; k++) begin
      req(vecs[k].src, vecs[k].code);
      collect(20);
      chk($sformatf("v%0d n_dv", k), 32'(n_dv), 32'd2);
      chk($sformatf("v%0d latency", k), 32'(dv_t[0]), 32'd1);
      chk($sformatf("v%0d msb_a", k), 32'(by_a[0]), 32'(vecs[k].exp_a[15:8]));
      chk($sformatf("v%0d lsb_a", k), 32'(by_a[1]), 32'(vecs[k].exp_a[7:0]));
      chk($sformatf("v%0d msb_b", k), 32'(by_b[0]), 32'(vecs[k].exp_b[15:8]));
      chk($sformatf("v%0d lsb_b", k), 32'(by_b[1]), 32'(vecs[k].exp_b[7:0]));
      chk($sformatf("v%0d n_done", k), 32'(n_done), 32'd1);
      chk($sformatf("v%0d last_a", k), 32'(bus_a.o_Last_Code), 32'(vecs[k].exp_a));
      chk($sformatf("v%0d last_b", k), 32'(bus_b.o_Last_Code), 32'(vecs[k].exp_b));
      chk($sformatf("v%0d src", k), 32'(bus_a.o_Last_Src), 32'(vecs[k].src));
      chk($sformatf("v%0d busy", k), 32'(bus_a.o_Busy), 32'd0);
      chk($sformatf("v%0d b2b_dv", k), 32'(b2b), 32'd0);
      chk($sformatf("v%0d byte_hold", k), 32'(unstable), 32'd0);
      chk($sformatf("v%0d lockstep", k), 32'(desync), 32'd0);
    end
    chk("table drops", 32'(bus_a.o_Drop_Count), 32'd0);

    // loop and manual in the same cycle: loop first, manual after exactly the gap
    @(posedge clk);
    #1;
    bus_a.i_Loop_Code = 16'h1357; bus_a.i_Loop_Valid = 1'b1;
    bus_a.i_Man_Code  = 16'h2468; bus_a.i_Man_Valid  = 1'b1;
    @(posedge clk);
    #1;
    bus_a.i_Loop_Valid = 1'b0; bus_a.i_Man_Valid = 1'b0;
    collect(35);
    chk_bytes("both", 8'h13, 8'h57, 8'h24, 8'h68);
    chk("both gap", 32'(dv_t[2] - done_t[0]), 32'(GAP + 1));
    chk("both last", 32'(bus_a.o_Last_Code), 32'h2468);
    chk("both src", 32'(bus_a.o_Last_Src), 32'd1);
    chk("both drops", 32'(bus_a.o_Drop_Count), 32'd0);

    // 100 is granted at once; 200 is overwritten by 300 while busy
    fork
      collect(45);
      begin
        req(1'b0, 16'd100);
        req(1'b0, 16'd200);
        req(1'b0, 16'd300);
      end
    join
    chk_bytes("latest", 8'h00, 8'h64, 8'h01, 8'h2C);
    chk("latest last", 32'(bus_a.o_Last_Code), 32'h012C);
    chk("latest src", 32'(bus_a.o_Last_Src), 32'd0);
    chk("latest drops", 32'(bus_a.o_Drop_Count), 32'd1);

    // override clears a pending loop code and blocks new ones; manual still served
    fork
      collect(45);
      begin
        req(1'b1, 16'h0101);
        req(1'b0, 16'h5555);
        bus_a.i_Man_Override = 1'b1;
        req(1'b0, 16'h7777);
        req(1'b1, 16'h3C3C);
      end
    join
    chk_bytes("ovr", 8'h01, 8'h01, 8'h3C, 8'h3C);
    chk("ovr last", 32'(bus_a.o_Last_Code), 32'h3C3C);
    chk("ovr drops", 32'(bus_a.o_Drop_Count), 32'd2);
    bus_a.i_Man_Override = 1'b0;
    collect(15);
    chk("ovr cleared", 32'(n_dv), 32'd0);

    // ready stuck low after the MSB: timeout, no completion, back to idle after the gap
    stall = 1'b1;
    req(1'b1, 16'hBEEF);
    t_dv = -1; t_err = -1; t_idle = -1; nd = 0; ndv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_a.o_TX_DV) begin
        ndv++;
        if (t_dv < 0) t_dv = i;
      end
      if (bus_a.o_Timeout_Err && t_err < 0) t_err = i;
      if (t_err >= 0 && !bus_a.o_Busy && t_idle < 0) t_idle = i;
      if (bus_a.o_Update_Done) nd++;
    end
    chk("tmo dv_count", 32'(ndv), 32'd1);
    chk("tmo err_time", 32'(t_err - t_dv), 32'(TMO));
    chk("tmo idle_time", 32'(t_idle - t_dv), 32'(TMO + GAP));
    chk("tmo no_done", 32'(nd), 32'd0);
    chk("tmo last", 32'(bus_a.o_Last_Code), 32'h3C3C);
    chk("tmo err_b", 32'(bus_b.o_Timeout_Err), 32'd1);
    stall = 1'b0;
    collect(15);
    chk("tmo discarded", 32'(n_dv), 32'd0);
    req(1'b1, 16'h4242);
    collect(20);
    chk("recover n_dv", 32'(n_dv), 32'd2);
    chk("recover last", 32'(bus_a.o_Last_Code), 32'h4242);
    chk("err sticky", 32'(bus_a.o_Timeout_Err), 32'd1);

    // reset in the middle of a transfer
    req(1'b1, 16'h9999);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst busy", 32'(bus_a.o_Busy), 32'd0);
    chk("mid_rst err", 32'(bus_a.o_Timeout_Err), 32'd0);
    chk("mid_rst last", 32'(bus_a.o_Last_Code), 32'd0);
    chk("mid_rst byte", 32'(bus_a.o_TX_Byte), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    collect(15);
    chk("post_rst no_dv", 32'(n_dv), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
